pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl_pkg.sv | 15 +
 rtl/branch_target_gen.sv | 31 +++
 rtl/defines.vh | 13 +
 rtl/pc_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Types and constants shared by the PC sequencer and its target generator.
package pc_seq_ctrl_pkg;
`include "defines.vh"

    localparam int DW = `DATALENGTH;
    localparam logic [DW-1:0] RESET_PC_DEF = `RESET_PC_DEFAULT;
    localparam logic [DW-1:0] EXC_VEC_DEF  = `EXC_VEC_DEFAULT;

    typedef enum logic [1:0] {
        ST_BOOT = `STATE_BOOT_ENC,
        ST_RUN  = `STATE_RUN_ENC,
        ST_PEND = `STATE_PEND_ENC
    } state_e;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational D-stage redirect target: branch, J-type and JR targets plus priority select.
module branch_target_gen
    import pc_seq_ctrl_pkg::*;
(
    input  logic          branch_taken_d,
    input  logic          jump_d,
    input  logic          jump_reg_d,
    input  logic [DW-1:0] sign_imm_d,
    input  logic [DW-1:0] pc_plus4_d,
    input  logic [25:0]   instr_index_d,
    input  logic [DW-1:0] rs_value_d,
    output logic          redirect,
    output logic [DW-1:0] target
);
    logic [DW-1:0] br_target;
    logic [DW-1:0] j_target;

    // Offset is in words; the shift drops the top two sign bits and the add wraps.
    assign br_target = pc_plus4_d + (sign_imm_d << 2);
    assign j_target  = {pc_plus4_d[DW-1:DW-4], instr_index_d, 2'b00};
    assign redirect  = branch_taken_d | jump_d | jump_reg_d;

    always_comb begin
        target = br_target;
        if (jump_reg_d) begin
            target = rs_value_d;
        end else if (jump_d) begin
            target = j_target;
        end
    end
endmodule

// File: rtl/defines.vh
// Shared widths, boot/exception vector defaults and FSM state encodings for pc_seq_ctrl.
`ifndef PC_SEQ_CTRL_DEFINES_VH
`define PC_SEQ_CTRL_DEFINES_VH

`define DATALENGTH        32
`define RESET_PC_DEFAULT  32'hBFC0_0000
`define EXC_VEC_DEFAULT   32'hBFC0_0380

`define STATE_BOOT_ENC    2'd0
`define STATE_RUN_ENC     2'd1
`define STATE_PEND_ENC    2'd2

`endif

// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer with BOOT/RUN/PEND FSM that parks stalled redirects until fetch resumes.
// Optional misaligned JR/ERET trapping is enabled by defining BRANCH_ALIGN_CHECK_EN.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [DW-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [DW-1:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall_f,
    input  logic          branch_taken_d,
    input  logic          jump_d,
    input  logic          jump_reg_d,
    input  logic [DW-1:0] SignImmD,
    input  logic [DW-1:0] pc_plus4_d,
    input  logic [25:0]   instr_index_d,
    input  logic [DW-1:0] rs_value_d,
    input  logic          exc_req,
    input  logic          eret_req,
    input  logic [DW-1:0] epc,
    output logic [DW-1:0] pc_f,
    output logic          fetch_en,
    output logic          redirect_pending,
    output logic          addr_err
);
    state_e        state_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] pend_tgt_q;
    logic          fetch_en_q;
    logic          pend_q;
    logic          addr_err_q;

    logic          d_redirect;
    logic [DW-1:0] d_target;
    logic [DW-1:0] d_target_d;
    logic          jr_bad;
    logic          eret_bad;

    branch_target_gen u_target (
        .branch_taken_d (branch_taken_d),
        .jump_d         (jump_d),
        .jump_reg_d     (jump_reg_d),
        .sign_imm_d     (SignImmD),
        .pc_plus4_d     (pc_plus4_d),
        .instr_index_d  (instr_index_d),
        .rs_value_d     (rs_value_d),
        .redirect       (d_redirect),
        .target         (d_target)
    );

`ifdef BRANCH_ALIGN_CHECK_EN
    // JR has top select priority, so a selected JR target is always rs_value_d.
    assign jr_bad   = jump_reg_d && (rs_value_d[1:0] != 2'b00);
    assign eret_bad = (epc[1:0] != 2'b00);
`else
    assign jr_bad   = 1'b0;
    assign eret_bad = 1'b0;
`endif

    assign d_target_d = jr_bad ? EXC_VEC : d_target;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            fetch_en_q <= 1'b0;
            pend_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            if (exc_req || eret_req) begin
                pc_q       <= exc_req ? EXC_VEC : (eret_bad ? EXC_VEC : epc);
                addr_err_q <= !exc_req && eret_bad;
                pend_tgt_q <= '0;
                state_q    <= ST_RUN;
                fetch_en_q <= 1'b1;
                pend_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        state_q    <= ST_RUN;
                        fetch_en_q <= 1'b1;
                    end
                    ST_RUN: begin
                        // A misaligned JR flags addr_err when accepted, whether applied or parked.
                        if (!stall_f) begin
                            pc_q       <= d_redirect ? d_target_d : pc_q + DW'(4);
                            addr_err_q <= jr_bad;
                        end else if (d_redirect) begin
                            pend_tgt_q <= d_target_d;
                            state_q    <= ST_PEND;
                            pend_q     <= 1'b1;
                            addr_err_q <= jr_bad;
                        end
                    end
                    ST_PEND: begin
                        if (!stall_f) begin
                            pc_q       <= pend_tgt_q;
                            pend_tgt_q <= '0;
                            state_q    <= ST_RUN;
                            pend_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_BOOT;
                        fetch_en_q <= 1'b0;
                        pend_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc_f             = pc_q;
    assign fetch_en         = fetch_en_q;
    assign redirect_pending = pend_q;
    assign addr_err         = addr_err_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: literal checkpoints plus a per-cycle abstract model compare.
module tb_pc_seq_ctrl;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
`ifdef BRANCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_f, branch_taken_d, jump_d, jump_reg_d, exc_req, eret_req;
    logic [31:0] SignImmD, pc_plus4_d, rs_value_d, epc;
    logic [25:0] instr_index_d;
    logic [31:0] pc_f;
    logic        fetch_en, redirect_pending, addr_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    pc_seq_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .stall_f          (stall_f),
        .branch_taken_d   (branch_taken_d),
        .jump_d           (jump_d),
        .jump_reg_d       (jump_reg_d),
        .SignImmD         (SignImmD),
        .pc_plus4_d       (pc_plus4_d),
        .instr_index_d    (instr_index_d),
        .rs_value_d       (rs_value_d),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc_f             (pc_f),
        .fetch_en         (fetch_en),
        .redirect_pending (redirect_pending),
        .addr_err         (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: PC value, a "still booting" flag and a queue holding at most one parked target.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_err;
    logic [31:0] m_pend[$];
    logic [31:0] m_tgt;
    bit          m_bad;

    function automatic logic [31:0] model_target();
        if (jump_reg_d) return rs_value_d;
        if (jump_d) return {pc_plus4_d[31:28], instr_index_d, 2'b00};
        return pc_plus4_d + SignImmD * 32'd4;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc   = RST_PC;
            m_boot = 1'b1;
            m_err  = 1'b0;
            m_pend.delete();
        end else begin
            m_err = 1'b0;
            m_tgt = model_target();
            m_bad = ALIGN && jump_reg_d && (rs_value_d % 4 != 0);
            if (m_bad) m_tgt = EXC_PC;
            if (exc_req) begin
                m_pc = EXC_PC;
                m_boot = 1'b0;
                m_pend.delete();
            end else if (eret_req) begin
                m_boot = 1'b0;
                m_pend.delete();
                if (ALIGN && (epc % 4 != 0)) begin
                    m_pc = EXC_PC;
                    m_err = 1'b1;
                end else begin
                    m_pc = epc;
                end
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_pend.size() != 0) begin
                if (!stall_f) m_pc = m_pend.pop_front();
            end else if (branch_taken_d || jump_d || jump_reg_d) begin
                m_err = m_bad;
                if (stall_f) m_pend.push_back(m_tgt);
                else m_pc = m_tgt;
            end else if (!stall_f) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_pc_f", pc_f, m_pc);
            chk("model_fetch_en", 32'(fetch_en), 32'(!m_boot));
            chk("model_redirect_pending", 32'(redirect_pending), 32'(m_pend.size() != 0));
            chk("model_addr_err", 32'(addr_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        stall_f = 0; branch_taken_d = 0; jump_d = 0; jump_reg_d = 0;
        exc_req = 0; eret_req = 0;
    endtask

    task automatic set_branch(input logic [31:0] pcp4, input logic [31:0] imm);
        pc_plus4_d = pcp4; SignImmD = imm; branch_taken_d = 1;
    endtask

    initial begin
        reset = 0;
        clr();
        SignImmD = 0; pc_plus4_d = 0; rs_value_d = 0; epc = 0; instr_index_d = 0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_pc", pc_f, RST_PC);
        chk("rst_fetch_en", 32'(fetch_en), 0);
        chk("rst_pending", 32'(redirect_pending), 0);
        chk("rst_addr_err", 32'(addr_err), 0);

        reset = 1;
        #2 chk("boot_fetch_en", 32'(fetch_en), 0);
        tick(); chk("boot_pc0", pc_f, 32'hBFC0_0000); chk("run_fetch_en", 32'(fetch_en), 1);
        $display("[TB] boot: pc_f=%h fetch_en=%0d", pc_f, fetch_en);
        tick(); chk("seq_pc1", pc_f, 32'hBFC0_0004);
        tick(); chk("seq_pc2", pc_f, 32'hBFC0_0008);

        set_branch(32'hBFC0_0010, 32'h0000_0004);
        tick(); clr(); chk("branch_fwd", pc_f, 32'hBFC0_0020);
        $display("[TB] branch unstalled: pc_f=%h", pc_f);
        tick(); chk("after_branch", pc_f, 32'hBFC0_0024);

        stall_f = 1; set_branch(32'hBFC0_0010, 32'h0000_0004);
        tick(); chk("stall1_pc", pc_f, 32'hBFC0_0024); chk("stall1_pend", 32'(redirect_pending), 1);
        branch_taken_d = 0; jump_d = 1; pc_plus4_d = 32'hA000_0010; instr_index_d = 26'h40;
        tick(); chk("stall2_pc", pc_f, 32'hBFC0_0024);
        jump_d = 0;
        tick(); chk("stall3_pc", pc_f, 32'hBFC0_0024); chk("stall3_pend", 32'(redirect_pending), 1);
        stall_f = 0;
        tick(); chk("pend_apply", pc_f, 32'hBFC0_0020); chk("pend_clear", 32'(redirect_pending), 0);
        $display("[TB] stalled branch applied: pc_f=%h", pc_f);
        tick(); chk("pend_next", pc_f, 32'hBFC0_0024);

        set_branch(32'h0000_1000, 32'hFFFF_FFF0);
        tick(); clr(); chk("branch_back", pc_f, 32'h0000_0FC0);
        set_branch(32'h0000_0000, 32'hFFFF_FFFF);
        tick(); clr(); chk("branch_wrap", pc_f, 32'hFFFF_FFFC);
        tick(); chk("pc_wrap", pc_f, 32'h0000_0000);
        $display("[TB] wrap: pc_f=%h", pc_f);

        stall_f = 1; jump_d = 1; pc_plus4_d = 32'hA000_0010; instr_index_d = 26'h40;
        tick(); chk("park_jump", 32'(redirect_pending), 1);
        jump_d = 0; exc_req = 1; jump_reg_d = 1; rs_value_d = 32'h1234_5678;
        tick(); clr(); chk("exc_pc", pc_f, 32'hBFC0_0380); chk("exc_pend", 32'(redirect_pending), 0);
        tick(); chk("exc_next", pc_f, 32'hBFC0_0384);
        $display("[TB] exception: pc_f=%h", pc_f);

        jump_reg_d = 1; jump_d = 1; set_branch(32'hA000_0010, 32'h4); rs_value_d = 32'h0040_0000;
        tick(); clr(); chk("prio_jr", pc_f, 32'h0040_0000);
        jump_d = 1; set_branch(32'hA000_0010, 32'h4);
        tick(); clr(); chk("prio_j", pc_f, 32'hA000_0100);

        eret_req = 1; epc = 32'h8000_1000; stall_f = 1; set_branch(32'hBFC0_0010, 32'h4);
        tick(); clr(); chk("eret_pc", pc_f, 32'h8000_1000); chk("eret_pend", 32'(redirect_pending), 0);
        exc_req = 1; eret_req = 1;
        tick(); clr(); chk("exc_over_eret", pc_f, 32'hBFC0_0380);
        $display("[TB] eret/exc: pc_f=%h", pc_f);

        jump_reg_d = 1; rs_value_d = 32'h8000_0002;
        tick(); clr();
        chk("jr_misalign_pc", pc_f, ALIGN ? 32'hBFC0_0380 : 32'h8000_0002);
        chk("jr_misalign_err", 32'(addr_err), 32'(ALIGN));
        tick(); chk("addr_err_pulse", 32'(addr_err), 0);
        $display("[TB] misaligned JR: pc_f=%h", pc_f);

        stall_f = 1; set_branch(32'hBFC0_0010, 32'h4);
        tick(); chk("pre_reset_pend", 32'(redirect_pending), 1);
        #2 reset = 0;
        #1;
        chk("async_pend", 32'(redirect_pending), 0);
        chk("async_pc", pc_f, RST_PC);
        chk("async_fetch_en", 32'(fetch_en), 0);
        clr();
        tick();
        reset = 1;
        tick(); chk("rerun_pc", pc_f, 32'hBFC0_0000);
        tick(); chk("rerun_next", pc_f, 32'hBFC0_0004); chk("rerun_pend", 32'(redirect_pending), 0);
        $display("[TB] async reset mid-PEND: pc_f=%h", pc_f);

        @(negedge clock);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
